// File: rtl/cpu_run_ctrl.sv
// Run/debug controller for the pipelined CPU: releases CPU reset, counts run cycles,
// and stalls the CPU to stream the register file out on end count, halt or period.
module cpu_run_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned END_COUNT   = 100,
  parameter int unsigned DUMP_PERIOD = 0,
  localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halt_i,
  output logic              cpu_rst_n_o,
  output logic              cpu_stall_o,
  output logic [IDX_W-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_final_o,
  output logic [CNT_W-1:0]  run_cnt_o,
  output logic              done_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] END_LAST    = CNT_W'(END_COUNT - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(DUMP_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_REGS - 1);
  localparam bit               PERIOD_EN   = (DUMP_PERIOD != 0);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    RUN      = 3'd1,
    DUMP_RD  = 3'd2,
    DUMP_OUT = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e state, state_nxt;

  logic [CNT_W-1:0]  hold_cnt, hold_cnt_d;
  logic [CNT_W-1:0]  period_cnt, period_cnt_d;
  logic [CNT_W-1:0]  run_cnt_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic              final_q, final_d;
  logic              halt_q, halt_d;
  logic              valid_d, dump_final_d, stall_d, rst_n_d, done_d;
  logic [IDX_W-1:0]  dump_idx_d;
  logic [DATA_W-1:0] dump_data_d;

  logic end_hit, period_hit, handshake, last_idx, final_any;

  assign end_hit    = (run_cnt_o == END_LAST);
  assign period_hit = PERIOD_EN && (period_cnt == PERIOD_LAST);
  assign handshake  = dump_valid_o && dump_ready_i;
  assign last_idx   = (idx == IDX_LAST);
  // A halt seen at any point of a non-final pass turns its completion into the final one
  assign final_any  = final_q || halt_q || halt_i;
  assign rf_addr_o  = idx;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= HOLD;
    else       state <= state_nxt;
  end

  // Next-state logic; end/halt take precedence over a coincident period hit
  always_comb begin
    state_nxt = state;
    case (state)
      HOLD:     if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      RUN:      if (end_hit || halt_i || period_hit) state_nxt = DUMP_RD;
      DUMP_RD:  state_nxt = DUMP_OUT;
      DUMP_OUT: begin
        if (handshake) begin
          if (!last_idx)      state_nxt = DUMP_RD;
          else if (final_any) state_nxt = DONE;
          else                state_nxt = RUN;
        end
      end
      DONE:     state_nxt = DONE;
      default:  state_nxt = HOLD;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    hold_cnt_d   = hold_cnt;
    run_cnt_d    = run_cnt_o;
    period_cnt_d = period_cnt;
    idx_d        = idx;
    final_d      = final_q;
    halt_d       = halt_q;
    valid_d      = dump_valid_o;
    dump_idx_d   = dump_idx_o;
    dump_data_d  = dump_data_o;
    dump_final_d = dump_final_o;
    case (state)
      HOLD: hold_cnt_d = hold_cnt + CNT_W'(1);
      RUN: begin
        run_cnt_d    = run_cnt_o + CNT_W'(1);
        period_cnt_d = period_cnt + CNT_W'(1);
        if (end_hit || halt_i) begin
          final_d = 1'b1;
          idx_d   = '0;
        end else if (period_hit) begin
          period_cnt_d = '0;
          idx_d        = '0;
        end
      end
      DUMP_RD: begin
        dump_data_d  = rf_data_i;
        dump_idx_d   = idx;
        valid_d      = 1'b1;
        dump_final_d = final_q || halt_q;
        halt_d       = halt_q || halt_i;
      end
      DUMP_OUT: begin
        halt_d = halt_q || halt_i;
        if (handshake) begin
          valid_d = 1'b0;
          if (!last_idx) idx_d = idx + IDX_W'(1);
        end
      end
      DONE:    valid_d = 1'b0;
      default: valid_d = 1'b0;
    endcase
    stall_d = (state_nxt == DUMP_RD) || (state_nxt == DUMP_OUT) || (state_nxt == DONE);
    rst_n_d = (state_nxt != HOLD);
    done_d  = (state_nxt == DONE);
  end

  // Registered outputs and internal counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt     <= '0;
      period_cnt   <= '0;
      run_cnt_o    <= '0;
      idx          <= '0;
      final_q      <= 1'b0;
      halt_q       <= 1'b0;
      dump_valid_o <= 1'b0;
      dump_idx_o   <= '0;
      dump_data_o  <= '0;
      dump_final_o <= 1'b0;
      cpu_stall_o  <= 1'b0;
      cpu_rst_n_o  <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      hold_cnt     <= hold_cnt_d;
      period_cnt   <= period_cnt_d;
      run_cnt_o    <= run_cnt_d;
      idx          <= idx_d;
      final_q      <= final_d;
      halt_q       <= halt_d;
      dump_valid_o <= valid_d;
      dump_idx_o   <= dump_idx_d;
      dump_data_o  <= dump_data_d;
      dump_final_o <= dump_final_d;
      cpu_stall_o  <= stall_d;
      cpu_rst_n_o  <= rst_n_d;
      done_o       <= done_d;
    end
  end

endmodule
